// File: rtl/am_modulator.sv
// ---------------------------------------------------------------------------
// am_modulator
//
// Transmit-side AM modulator. Signed audio samples arrive over a valid/ready
// handshake and are held (zero-order hold) together with a modulation depth.
// An envelope is formed as a fixed carrier offset plus the depth-scaled
// audio. The envelope is multiplied by a quadrature NCO (phase accumulator
// feeding a quarter-wave sine table) to give an I/Q pair whose magnitude
// tracks the envelope.
//
// Ports
//   clk             rising-edge system clock
//   rst             synchronous, active-high reset
//   enable          advances the NCO and feeds the output-valid pipeline
//   phase_inc       unsigned NCO tuning word, used on every enabled cycle
//   mod_depth       unsigned Q0.8 depth, captured with each accepted sample
//   audio_in        signed audio sample
//   audio_valid     audio_in carries a sample
//   audio_ready     a sample can be accepted (low only while rst is high)
//   inphase_out     signed I = env * cos(phase)
//   quadrature_out  signed Q = env * sin(phase)
//   out_valid       I/Q outputs carry pipeline-filled data
//
// Latency: the outputs after edge t+3 reflect phase_acc and env as they were
// after edge t. out_valid is enable delayed by three registers.
// ---------------------------------------------------------------------------
module am_modulator #(
  parameter int DATA_WIDTH     = 12,
  parameter int PHASE_WIDTH    = 24,
  parameter int LUT_ADDR_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [PHASE_WIDTH-1:0]       phase_inc,
  input  logic [7:0]                   mod_depth,
  input  logic signed [DATA_WIDTH-1:0] audio_in,
  input  logic                         audio_valid,
  output logic                         audio_ready,
  output logic signed [DATA_WIDTH-1:0] inphase_out,
  output logic signed [DATA_WIDTH-1:0] quadrature_out,
  output logic                         out_valid
);

  localparam int LUT_DEPTH = 2 ** LUT_ADDR_WIDTH;
  localparam int SCALE_W   = DATA_WIDTH + 9;
  localparam int PROD_W    = 2 * DATA_WIDTH;

  // Carrier level of the envelope: half of full scale, so that a full-depth
  // full-scale sample swings the envelope between near zero and near full.
  localparam logic signed [DATA_WIDTH-1:0] ENV_OFFSET =
    DATA_WIDTH'(2 ** (DATA_WIDTH - 2));

  localparam real PI      = 3.14159265358979323846;
  localparam real LUT_AMP = real'(2 ** (DATA_WIDTH - 1) - 1);

  // -------------------------------------------------------------------------
  // Arithmetic helpers
  // -------------------------------------------------------------------------

  // (audio * depth) >>> 9 with floor rounding. depth is Q0.8, the extra
  // halving keeps the modulated envelope inside the positive signed range.
  function automatic logic signed [DATA_WIDTH-1:0] scale_audio(
    input logic signed [DATA_WIDTH-1:0] audio,
    input logic        [7:0]            depth
  );
    logic signed [SCALE_W-1:0] audio_x;
    logic signed [SCALE_W-1:0] depth_x;
    logic signed [SCALE_W-1:0] prod;
    audio_x = SCALE_W'(audio);
    depth_x = SCALE_W'($signed({1'b0, depth}));
    prod    = audio_x * depth_x;
    return DATA_WIDTH'(prod >>> 9);
  endfunction

  // Full-precision signed product of envelope and carrier sample.
  function automatic logic signed [PROD_W-1:0] mul_full(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [PROD_W-1:0] a_x;
    logic signed [PROD_W-1:0] b_x;
    a_x = PROD_W'(a);
    b_x = PROD_W'(b);
    return a_x * b_x;
  endfunction

  // Drop the table's Q1.(DATA_WIDTH-1) scaling with floor truncation. The
  // envelope magnitude stays below 2^(DATA_WIDTH-1), so the result always
  // fits and no saturation stage is needed.
  function automatic logic signed [DATA_WIDTH-1:0] mul_trunc(
    input logic signed [PROD_W-1:0] prod
  );
    return DATA_WIDTH'(prod >>> (DATA_WIDTH - 1));
  endfunction

  // Rebuild a full-wave sample from the quarter-wave table. Odd quadrants
  // read the mirrored address, the upper half of the circle is negated.
  function automatic logic signed [DATA_WIDTH-1:0] quarter_fold(
    input logic [1:0]            quad,
    input logic [DATA_WIDTH-1:0] direct,
    input logic [DATA_WIDTH-1:0] mirror
  );
    logic signed [DATA_WIDTH-1:0] mag;
    mag = quad[0] ? $signed(mirror) : $signed(direct);
    return quad[1] ? -mag : mag;
  endfunction

  // -------------------------------------------------------------------------
  // Quarter-wave sine table, built at elaboration. Entries sit at the
  // centres of their address bins (k + 0.5), so mirroring is exact and no
  // output ever lands on zero.
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] lut_rom [LUT_DEPTH];

  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
    localparam real ANG = PI / 2.0 * (real'(k) + 0.5) / real'(LUT_DEPTH);
    localparam int  VAL = $rtoi(LUT_AMP * $sin(ANG) + 0.5);
    assign lut_rom[k] = VAL[DATA_WIDTH-1:0];
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  logic [PHASE_WIDTH-1:0]       phase_acc_q, phase_acc_d;
  logic signed [DATA_WIDTH-1:0] audio_hold_q, audio_hold_d;
  logic [7:0]                   depth_hold_q, depth_hold_d;
  logic signed [DATA_WIDTH-1:0] env_q, env_d;

  logic signed [DATA_WIDTH-1:0] sin_p0_q, sin_d;
  logic signed [DATA_WIDTH-1:0] cos_p0_q, cos_d;
  logic signed [DATA_WIDTH-1:0] env_p0_q;
  logic signed [PROD_W-1:0]     prod_i_p1_q, prod_i_d;
  logic signed [PROD_W-1:0]     prod_q_p1_q, prod_q_d;
  logic signed [DATA_WIDTH-1:0] i_p2_q, i_d;
  logic signed [DATA_WIDTH-1:0] q_p2_q, q_d;
  logic                         vld_p0_q, vld_p1_q, vld_p2_q;

  logic                         accept;
  logic [1:0]                   quad_sin, quad_cos;
  logic [LUT_ADDR_WIDTH-1:0]    lut_addr;
  logic [DATA_WIDTH-1:0]        lut_direct, lut_mirror;

  // Ready depends only on reset, so the handshake resumes on the very first
  // edge with rst low and a sample offered during reset is never taken.
  assign audio_ready = ~rst;
  assign accept      = audio_valid & audio_ready;

  assign quad_sin = phase_acc_q[PHASE_WIDTH-1 -: 2];
  assign quad_cos = quad_sin + 2'd1;
  assign lut_addr = phase_acc_q[PHASE_WIDTH-3 -: LUT_ADDR_WIDTH];

  always_comb begin
    phase_acc_d  = enable ? phase_acc_q + phase_inc : phase_acc_q;
    audio_hold_d = accept ? audio_in  : audio_hold_q;
    depth_hold_d = accept ? mod_depth : depth_hold_q;
    env_d        = ENV_OFFSET + scale_audio(audio_hold_q, depth_hold_q);

    lut_direct   = lut_rom[lut_addr];
    lut_mirror   = lut_rom[~lut_addr];
    sin_d        = quarter_fold(quad_sin, lut_direct, lut_mirror);
    cos_d        = quarter_fold(quad_cos, lut_direct, lut_mirror);

    prod_i_d     = mul_full(env_p0_q, cos_p0_q);
    prod_q_d     = mul_full(env_p0_q, sin_p0_q);

    i_d          = mul_trunc(prod_i_p1_q);
    q_d          = mul_trunc(prod_q_p1_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_acc_q  <= '0;
      audio_hold_q <= '0;
      depth_hold_q <= '0;
      env_q        <= ENV_OFFSET;
      sin_p0_q     <= '0;
      cos_p0_q     <= '0;
      env_p0_q     <= '0;
      prod_i_p1_q  <= '0;
      prod_q_p1_q  <= '0;
      i_p2_q       <= '0;
      q_p2_q       <= '0;
      vld_p0_q     <= 1'b0;
      vld_p1_q     <= 1'b0;
      vld_p2_q     <= 1'b0;
    end else begin
      phase_acc_q  <= phase_acc_d;
      audio_hold_q <= audio_hold_d;
      depth_hold_q <= depth_hold_d;
      env_q        <= env_d;
      // ---- stage p0: carrier samples from the table, envelope aligned ----
      sin_p0_q     <= sin_d;
      cos_p0_q     <= cos_d;
      env_p0_q     <= env_q;
      vld_p0_q     <= enable;
      // ---- stage p1: full-precision envelope x carrier products ----
      prod_i_p1_q  <= prod_i_d;
      prod_q_p1_q  <= prod_q_d;
      vld_p1_q     <= vld_p0_q;
      // ---- stage p2: rescaled I/Q output registers ----
      i_p2_q       <= i_d;
      q_p2_q       <= q_d;
      vld_p2_q     <= vld_p1_q;
    end
  end

  assign inphase_out    = i_p2_q;
  assign quadrature_out = q_p2_q;
  assign out_valid      = vld_p2_q;

endmodule
